// File: rtl/ifm_buf_reader.sv
// ifm_buf_reader: read-side controller for three ping-pong ifmap buffers.
// Queues filled buffers in completion order and streams one DEPTH-row tile per rd_go.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_i2c_finish_0/1/2             one-cycle pulse: buffer N filled
//   i_rd_go                        request the next tile
//   i_pixels_from_buffer_0/1/2     buffer read data (1-cycle read latency)
//   o_ifm_rd_en_0/1/2              per-bank read enables of buffer N
//   o_ifm_rd_addr_0/1/2            per-bank row address of buffer N
//   o_buf_empty_0/1/2              buffer N free for filling
//   o_pixels_to_array, o_pixels_valid, o_tile_first, o_tile_last, o_tile_done
//   o_buf_avail, o_rd_busy, o_seq_err
module ifm_buf_reader #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_i2c_finish_0,
    input  logic                     i_i2c_finish_1,
    input  logic                     i_i2c_finish_2,
    input  logic                     i_rd_go,
    input  logic [DATA_W-1:0]        i_pixels_from_buffer_0,
    input  logic [DATA_W-1:0]        i_pixels_from_buffer_1,
    input  logic [DATA_W-1:0]        i_pixels_from_buffer_2,
    output logic [SIZE-1:0]          o_ifm_rd_en_0,
    output logic [SIZE-1:0]          o_ifm_rd_en_1,
    output logic [SIZE-1:0]          o_ifm_rd_en_2,
    output logic [SIZE*ADDR_W-1:0]   o_ifm_rd_addr_0,
    output logic [SIZE*ADDR_W-1:0]   o_ifm_rd_addr_1,
    output logic [SIZE*ADDR_W-1:0]   o_ifm_rd_addr_2,
    output logic                     o_buf_empty_0,
    output logic                     o_buf_empty_1,
    output logic                     o_buf_empty_2,
    output logic [DATA_W-1:0]        o_pixels_to_array,
    output logic                     o_pixels_valid,
    output logic                     o_tile_first,
    output logic                     o_tile_last,
    output logic                     o_tile_done,
    output logic                     o_buf_avail,
    output logic                     o_rd_busy,
    output logic                     o_seq_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FULL    = 2'd1,
        B_READING = 2'd2
    } bstat_t;

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

    // control state
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_row;
    logic [ADDR_W-1:0]   w_row_nxt;
    logic                r_drn;
    logic                w_drn_nxt;
    logic [1:0]          r_sel;
    logic [1:0]          w_sel_nxt;
    logic                r_seq_err;
    logic                w_seq_err_nxt;
    bstat_t              r_stat [3];
    bstat_t              w_stat_nxt [3];

    // completion-order queue, head at index 0
    logic [1:0]          r_q [3];
    logic [1:0]          w_q_nxt [3];
    logic [1:0]          r_cnt;
    logic [1:0]          w_cnt_nxt;
    logic                w_pop;
    logic [2:0]          w_fin;

    // read-data pipeline
    logic                w_rd;
    logic                r_v1;
    logic [ADDR_W-1:0]   r_row_d1;
    logic [1:0]          r_sel_d1;
    logic                r_valid;
    logic                r_first;
    logic                r_last;
    logic [DATA_W-1:0]   r_pix;
    logic [DATA_W-1:0]   w_pix_mux;

    assign w_fin = {i_i2c_finish_2, i_i2c_finish_1, i_i2c_finish_0};
    assign w_rd  = (r_state == S_READ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_drn     <= 1'b0;
            r_sel     <= 2'd0;
            r_seq_err <= 1'b0;
            r_cnt     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_stat[i] <= B_EMPTY;
                r_q[i]    <= 2'd0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_drn     <= w_drn_nxt;
            r_sel     <= w_sel_nxt;
            r_seq_err <= w_seq_err_nxt;
            r_cnt     <= w_cnt_nxt;
            for (int i = 0; i < 3; i++) begin
                r_stat[i] <= w_stat_nxt[i];
                r_q[i]    <= w_q_nxt[i];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_drn_nxt     = r_drn;
        w_sel_nxt     = r_sel;
        w_seq_err_nxt = r_seq_err;
        w_cnt_nxt     = r_cnt;
        w_pop         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_stat_nxt[i] = r_stat[i];
            w_q_nxt[i]    = r_q[i];
        end

        case (r_state)
            S_IDLE: begin
                if (i_rd_go && (r_cnt != 2'd0)) begin
                    w_pop       = 1'b1;
                    w_sel_nxt   = r_q[0];
                    w_row_nxt   = '0;
                    w_state_nxt = S_READ;
                    for (int i = 0; i < 3; i++) begin
                        if (r_q[0] == 2'(i)) begin
                            w_stat_nxt[i] = B_READING;
                        end
                    end
                end
            end
            S_READ: begin
                w_row_nxt = r_row + 1'b1;
                if (r_row == LP_LAST) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // two cycles: let the last rows clear the read pipeline
                w_drn_nxt = ~r_drn;
                if (r_drn) begin
                    w_state_nxt = S_IDLE;
                    for (int i = 0; i < 3; i++) begin
                        if (r_sel == 2'(i)) begin
                            w_stat_nxt[i] = B_EMPTY;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // pop first so same-cycle pushes land behind the remaining entries
        if (w_pop) begin
            w_q_nxt[0] = r_q[1];
            w_q_nxt[1] = r_q[2];
            w_q_nxt[2] = 2'd0;
            w_cnt_nxt  = r_cnt - 2'd1;
        end

        // ascending index order for simultaneous finishes
        for (int i = 0; i < 3; i++) begin
            if (w_fin[i]) begin
                if (r_stat[i] == B_EMPTY) begin
                    for (int j = 0; j < 3; j++) begin
                        if (w_cnt_nxt == 2'(j)) begin
                            w_q_nxt[j] = 2'(i);
                        end
                    end
                    if (w_cnt_nxt != 2'd3) begin
                        w_cnt_nxt = w_cnt_nxt + 2'd1;
                    end
                    w_stat_nxt[i] = B_FULL;
                end else begin
                    w_seq_err_nxt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (r_sel_d1)
            2'd0:    w_pix_mux = i_pixels_from_buffer_0;
            2'd1:    w_pix_mux = i_pixels_from_buffer_1;
            2'd2:    w_pix_mux = i_pixels_from_buffer_2;
            default: w_pix_mux = i_pixels_from_buffer_0;
        endcase
    end

    // r_v1/r_row_d1/r_sel_d1 line up with the buffer's read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1     <= 1'b0;
            r_row_d1 <= '0;
            r_sel_d1 <= 2'd0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_pix    <= '0;
        end else begin
            r_v1     <= w_rd;
            r_row_d1 <= r_row;
            r_sel_d1 <= r_sel;
            r_valid  <= r_v1;
            r_first  <= r_v1 && (r_row_d1 == '0);
            r_last   <= r_v1 && (r_row_d1 == LP_LAST);
            if (r_v1) begin
                r_pix <= w_pix_mux;
            end
        end
    end

    always_comb begin
        o_ifm_rd_en_0   = '0;
        o_ifm_rd_en_1   = '0;
        o_ifm_rd_en_2   = '0;
        o_ifm_rd_addr_0 = '0;
        o_ifm_rd_addr_1 = '0;
        o_ifm_rd_addr_2 = '0;
        if (w_rd) begin
            case (r_sel)
                2'd0: begin
                    o_ifm_rd_en_0   = '1;
                    o_ifm_rd_addr_0 = {SIZE{r_row}};
                end
                2'd1: begin
                    o_ifm_rd_en_1   = '1;
                    o_ifm_rd_addr_1 = {SIZE{r_row}};
                end
                2'd2: begin
                    o_ifm_rd_en_2   = '1;
                    o_ifm_rd_addr_2 = {SIZE{r_row}};
                end
                default: begin
                    o_ifm_rd_en_0 = '0;
                end
            endcase
        end
    end

    assign o_buf_empty_0     = (r_stat[0] == B_EMPTY);
    assign o_buf_empty_1     = (r_stat[1] == B_EMPTY);
    assign o_buf_empty_2     = (r_stat[2] == B_EMPTY);
    assign o_pixels_to_array = r_pix;
    assign o_pixels_valid    = r_valid;
    assign o_tile_first      = r_first;
    assign o_tile_last       = r_last;
    assign o_tile_done       = r_last;
    assign o_buf_avail       = (r_cnt != 2'd0);
    assign o_rd_busy         = (r_state != S_IDLE);
    assign o_seq_err         = r_seq_err;

endmodule
